// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_fsm
//  Description : Main sequencer for a multi-cycle RISC-V datapath. Steps one
//                shared ALU/memory through fetch, decode, execute, memory and
//                writeback; waits on a memory ready handshake, counts retired
//                instructions and traps on illegal opcodes / memory timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 0,   // max wait cycles per memory access; 0 = forever
    parameter int CNT_WIDTH   = 32   // width of the retired-instruction counter
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op_i,
    input  logic                 mem_ready_i,
    output logic                 pc_write_o,
    output logic                 branch_o,
    output logic                 ir_write_o,
    output logic                 adr_src_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 reg_write_o,
    output logic [1:0]           alu_src_a_o,
    output logic [1:0]           alu_src_b_o,
    output logic [2:0]           alu_op_o,
    output logic [1:0]           result_src_o,
    output logic [CNT_WIDTH-1:0] instret_o,
    output logic                 trap_o,
    output logic [1:0]           trap_cause_o
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    localparam logic [3:0] c_FETCH     = 4'd0;
    localparam logic [3:0] c_DECODE    = 4'd1;
    localparam logic [3:0] c_MEM_ADR   = 4'd2;
    localparam logic [3:0] c_MEM_READ  = 4'd3;
    localparam logic [3:0] c_MEM_WB    = 4'd4;
    localparam logic [3:0] c_MEM_WRITE = 4'd5;
    localparam logic [3:0] c_EXEC_R    = 4'd6;
    localparam logic [3:0] c_EXEC_I    = 4'd7;
    localparam logic [3:0] c_EXEC_LUI  = 4'd8;
    localparam logic [3:0] c_ALU_WB    = 4'd9;
    localparam logic [3:0] c_BRANCH    = 4'd10;
    localparam logic [3:0] c_JAL       = 4'd11;
    localparam logic [3:0] c_JALR      = 4'd12;
    localparam logic [3:0] c_JALR_PC   = 4'd13;
    localparam logic [3:0] c_TRAP      = 4'd14;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;
    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_BR    = 7'b1100011;
    localparam logic [6:0] c_OP_JAL   = 7'b1101111;
    localparam logic [6:0] c_OP_JALR  = 7'b1100111;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;

    localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;

    logic [3:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] instret_q;
    logic                 trap_q;
    logic [1:0]           cause_q, cause_d;
    logic                 w_retire;
    logic                 w_wait_last;
    logic                 w_mem_state;

    assign w_mem_state = (state_q == c_FETCH) || (state_q == c_MEM_READ) ||
                         (state_q == c_MEM_WRITE);

    // Wait counter: cleared on any state change, counts cycles spent stalled
    // in a memory state; only exists when a timeout is configured.
    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            logic [WAIT_W-1:0] wait_cnt_q;

            assign w_wait_last = (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1));

            // Count stall cycles; staying in a memory state implies not ready.
            always_ff @(posedge clk) begin
                if (reset) begin
                    wait_cnt_q <= '0;
                end else if (w_mem_state && (state_d == state_q)) begin
                    wait_cnt_q <= wait_cnt_q + 1'b1;
                end else begin
                    wait_cnt_q <= '0;
                end
            end
        end else begin : g_no_timeout
            assign w_wait_last = 1'b0;
        end
    endgenerate

    // Next-state, retire and trap-cause selection.
    always_comb begin
        state_d  = state_q;
        cause_d  = 2'b00;
        w_retire = 1'b0;
        case (state_q)
            c_FETCH: begin
                if (mem_ready_i) begin
                    state_d = c_DECODE;
                end else if (w_wait_last) begin
                    state_d = c_TRAP;
                    cause_d = c_CAUSE_TIMEOUT;
                end
            end
            c_DECODE: begin
                case (op_i)
                    c_OP_LOAD, c_OP_STORE: state_d = c_MEM_ADR;
                    c_OP_R:                state_d = c_EXEC_R;
                    c_OP_I:                state_d = c_EXEC_I;
                    c_OP_BR:               state_d = c_BRANCH;
                    c_OP_JAL:              state_d = c_JAL;
                    c_OP_JALR:             state_d = c_JALR;
                    c_OP_LUI:              state_d = c_EXEC_LUI;
                    default: begin
                        state_d = c_TRAP;
                        cause_d = c_CAUSE_ILLEGAL;
                    end
                endcase
            end
            c_MEM_ADR:   state_d = (op_i == c_OP_LOAD) ? c_MEM_READ : c_MEM_WRITE;
            c_MEM_READ: begin
                if (mem_ready_i) begin
                    state_d = c_MEM_WB;
                end else if (w_wait_last) begin
                    state_d = c_TRAP;
                    cause_d = c_CAUSE_TIMEOUT;
                end
            end
            c_MEM_WB: begin
                state_d  = c_FETCH;
                w_retire = 1'b1;
            end
            c_MEM_WRITE: begin
                if (mem_ready_i) begin
                    state_d  = c_FETCH;
                    w_retire = 1'b1;
                end else if (w_wait_last) begin
                    state_d = c_TRAP;
                    cause_d = c_CAUSE_TIMEOUT;
                end
            end
            c_EXEC_R, c_EXEC_I, c_EXEC_LUI: state_d = c_ALU_WB;
            c_ALU_WB, c_BRANCH: begin
                state_d  = c_FETCH;
                w_retire = 1'b1;
            end
            c_JAL:     state_d = c_ALU_WB;
            c_JALR:    state_d = c_JALR_PC;
            c_JALR_PC: state_d = c_ALU_WB;
            c_TRAP:    state_d = c_TRAP;
            default:   state_d = c_FETCH;
        endcase
    end

    // State, retire counter and sticky trap registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= c_FETCH;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            if (w_retire) begin
                instret_q <= instret_q + 1'b1;
            end
            // Only the entry into TRAP records a cause, so the first is kept.
            if ((state_d == c_TRAP) && (state_q != c_TRAP)) begin
                trap_q  <= 1'b1;
                cause_q <= cause_d;
            end
        end
    end

    // Control decode from the state register; FETCH write enables also wait
    // on ready, and reset suppresses every enable/strobe.
    always_comb begin
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        ir_write_o   = 1'b0;
        adr_src_o    = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 3'b000;
        result_src_o = 2'b00;
        case (state_q)
            c_FETCH: begin
                mem_read_o   = 1'b1;
                alu_src_b_o  = 2'b10;
                result_src_o = 2'b10;
                ir_write_o   = mem_ready_i;
                pc_write_o   = mem_ready_i;
            end
            c_DECODE: begin
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b01;
            end
            c_MEM_ADR, c_JALR: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
            end
            c_MEM_READ: begin
                adr_src_o  = 1'b1;
                mem_read_o = 1'b1;
            end
            c_MEM_WB: begin
                reg_write_o  = 1'b1;
                result_src_o = 2'b01;
            end
            c_MEM_WRITE: begin
                adr_src_o   = 1'b1;
                mem_write_o = 1'b1;
            end
            c_EXEC_R: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 3'b010;
            end
            c_EXEC_I: begin
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b01;
                alu_op_o    = 3'b011;
            end
            c_EXEC_LUI: begin
                alu_src_b_o = 2'b01;
                alu_op_o    = 3'b100;
            end
            c_ALU_WB: reg_write_o = 1'b1;
            c_BRANCH: begin
                alu_src_a_o = 2'b10;
                alu_op_o    = 3'b001;
                branch_o    = 1'b1;
            end
            c_JAL, c_JALR_PC: begin
                pc_write_o  = 1'b1;
                alu_src_a_o = 2'b01;
                alu_src_b_o = 2'b10;
            end
            default: ;
        endcase
        if (reset) begin
            pc_write_o  = 1'b0;
            branch_o    = 1'b0;
            ir_write_o  = 1'b0;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
            reg_write_o = 1'b0;
        end
    end

    assign instret_o    = instret_q;
    assign trap_o       = trap_q;
    assign trap_cause_o = cause_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control_fsm
//  Description : Directed self-checking bench for multicycle_control_fsm.
//                Instance 0: no timeout, 32-bit counter.
//                Instance 1: MEM_TIMEOUT=4, 3-bit counter (wrap check).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_fsm;

    // Packed control word: {pc_write, branch, ir_write, adr_src, mem_read,
    // mem_write, reg_write, src_a[1:0], src_b[1:0], alu_op[2:0], result_src[1:0]}
    localparam logic [15:0] c_E_ZERO    = 16'h0000;
    localparam logic [15:0] c_E_FETCH_W = {7'b0000100, 2'b00, 2'b10, 3'b000, 2'b10};
    localparam logic [15:0] c_E_FETCH_R = {7'b1010100, 2'b00, 2'b10, 3'b000, 2'b10};
    localparam logic [15:0] c_E_DECODE  = {7'b0000000, 2'b01, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] c_E_MEM_ADR = {7'b0000000, 2'b10, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] c_E_MEM_RD  = {7'b0001100, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] c_E_MEM_WB  = {7'b0000001, 2'b00, 2'b00, 3'b000, 2'b01};
    localparam logic [15:0] c_E_MEM_WR  = {7'b0001010, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] c_E_EXEC_R  = {7'b0000000, 2'b10, 2'b00, 3'b010, 2'b00};
    localparam logic [15:0] c_E_EXEC_I  = {7'b0000000, 2'b10, 2'b01, 3'b011, 2'b00};
    localparam logic [15:0] c_E_LUI     = {7'b0000000, 2'b00, 2'b01, 3'b100, 2'b00};
    localparam logic [15:0] c_E_ALU_WB  = {7'b0000001, 2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [15:0] c_E_BRANCH  = {7'b0100000, 2'b10, 2'b00, 3'b001, 2'b00};
    localparam logic [15:0] c_E_JAL     = {7'b1000000, 2'b01, 2'b10, 3'b000, 2'b00};
    localparam logic [15:0] c_E_JALR    = {7'b0000000, 2'b10, 2'b01, 3'b000, 2'b00};
    localparam logic [15:0] c_E_EN_MASK = 16'hFE00;

    localparam logic [6:0] c_LW   = 7'b0000011;
    localparam logic [6:0] c_SW   = 7'b0100011;
    localparam logic [6:0] c_RT   = 7'b0110011;
    localparam logic [6:0] c_ADDI = 7'b0010011;
    localparam logic [6:0] c_BEQ  = 7'b1100011;
    localparam logic [6:0] c_JALO = 7'b1101111;
    localparam logic [6:0] c_JALRO= 7'b1100111;
    localparam logic [6:0] c_LUIO = 7'b0110111;
    localparam logic [6:0] c_BAD  = 7'b1111111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      r_rst;
    logic [1:0][6:0] r_op;
    logic [1:0]      r_rdy;
    logic [1:0]      w_pw, w_br, w_ir, w_adr, w_mr, w_mw, w_rw, w_trap;
    logic [1:0][1:0] w_sa, w_sb, w_rs, w_cause;
    logic [1:0][2:0] w_aop;
    logic [31:0]     w_ret0;
    logic [2:0]      w_ret1;

    int n_cmp = 0;
    int n_err = 0;

    multicycle_control_fsm #(.MEM_TIMEOUT(0), .CNT_WIDTH(32)) u_dut0 (
        .clk(clk), .reset(r_rst[0]), .op_i(r_op[0]), .mem_ready_i(r_rdy[0]),
        .pc_write_o(w_pw[0]), .branch_o(w_br[0]), .ir_write_o(w_ir[0]),
        .adr_src_o(w_adr[0]), .mem_read_o(w_mr[0]), .mem_write_o(w_mw[0]),
        .reg_write_o(w_rw[0]), .alu_src_a_o(w_sa[0]), .alu_src_b_o(w_sb[0]),
        .alu_op_o(w_aop[0]), .result_src_o(w_rs[0]), .instret_o(w_ret0),
        .trap_o(w_trap[0]), .trap_cause_o(w_cause[0])
    );

    multicycle_control_fsm #(.MEM_TIMEOUT(4), .CNT_WIDTH(3)) u_dut1 (
        .clk(clk), .reset(r_rst[1]), .op_i(r_op[1]), .mem_ready_i(r_rdy[1]),
        .pc_write_o(w_pw[1]), .branch_o(w_br[1]), .ir_write_o(w_ir[1]),
        .adr_src_o(w_adr[1]), .mem_read_o(w_mr[1]), .mem_write_o(w_mw[1]),
        .reg_write_o(w_rw[1]), .alu_src_a_o(w_sa[1]), .alu_src_b_o(w_sb[1]),
        .alu_op_o(w_aop[1]), .result_src_o(w_rs[1]), .instret_o(w_ret1),
        .trap_o(w_trap[1]), .trap_cause_o(w_cause[1])
    );

    function automatic logic [15:0] ctrl(input int d);
        return {w_pw[d], w_br[d], w_ir[d], w_adr[d], w_mr[d], w_mw[d], w_rw[d],
                w_sa[d], w_sb[d], w_aop[d], w_rs[d]};
    endfunction

    function automatic logic [31:0] instret(input int d);
        return (d == 0) ? w_ret0 : {29'd0, w_ret1};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs for one cycle, check the control word mid-cycle, advance.
    task automatic step(input int d, input logic [6:0] o, input logic rdy,
                        input logic [15:0] e, input string tag);
        r_op[d]  = o;
        r_rdy[d] = rdy;
        @(negedge clk);
        check_eq(tag, {16'd0, ctrl(d)}, {16'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        r_rst[d] = 1'b1;
        r_rdy[d] = 1'b0;
        @(negedge clk);
        check_eq("rst_enables", {16'd0, ctrl(d) & c_E_EN_MASK}, 32'd0);
        @(posedge clk);
        #1;
        r_rst[d] = 1'b0;
        check_eq("rst_instret", instret(d), 32'd0);
        check_eq("rst_trap", {31'd0, w_trap[d]}, 32'd0);
        check_eq("rst_cause", {30'd0, w_cause[d]}, 32'd0);
    endtask

    task automatic run_addi(input int d);
        step(d, c_ADDI, 1'b1, c_E_FETCH_R, "addi_fetch");
        step(d, c_ADDI, 1'b1, c_E_DECODE,  "addi_decode");
        step(d, c_ADDI, 1'b1, c_E_EXEC_I,  "addi_exec");
        step(d, c_ADDI, 1'b1, c_E_ALU_WB,  "addi_wb");
    endtask

    initial begin
        r_rst = 2'b11;
        r_op  = '0;
        r_rdy = 2'b00;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- instance 0 ----------------
        do_reset(0);
        step(0, c_ADDI, 1'b0, c_E_FETCH_W, "fetch_wait");
        step(0, c_ADDI, 1'b1, c_E_FETCH_R, "addi_fetch");
        step(0, c_ADDI, 1'b1, c_E_DECODE,  "addi_decode");
        step(0, c_ADDI, 1'b1, c_E_EXEC_I,  "addi_exec");
        check_eq("addi_instret_pre", instret(0), 32'd0);
        step(0, c_ADDI, 1'b1, c_E_ALU_WB,  "addi_wb");
        check_eq("addi_instret", instret(0), 32'd1);

        // lw with three not-ready cycles in MEM_READ
        step(0, c_LW, 1'b1, c_E_FETCH_R, "lw_fetch");
        step(0, c_LW, 1'b1, c_E_DECODE,  "lw_decode");
        step(0, c_LW, 1'b1, c_E_MEM_ADR, "lw_adr");
        for (int i = 0; i < 3; i++) step(0, c_LW, 1'b0, c_E_MEM_RD, "lw_wait");
        step(0, c_LW, 1'b1, c_E_MEM_RD, "lw_ready");
        step(0, c_LW, 1'b0, c_E_MEM_WB, "lw_wb");
        check_eq("lw_instret", instret(0), 32'd2);

        // sw interrupted by reset while waiting
        step(0, c_SW, 1'b1, c_E_FETCH_R, "sw_fetch");
        step(0, c_SW, 1'b1, c_E_DECODE,  "sw_decode");
        step(0, c_SW, 1'b1, c_E_MEM_ADR, "sw_adr");
        step(0, c_SW, 1'b0, c_E_MEM_WR,  "sw_wait");
        r_rst[0] = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_memwrite", {31'd0, w_mw[0]}, 32'd0);
        @(posedge clk);
        #1;
        r_rst[0] = 1'b0;
        check_eq("rst_mid_instret", instret(0), 32'd0);
        step(0, c_JALO, 1'b0, c_E_FETCH_W, "after_rst_fetch");

        // jal then jalr
        step(0, c_JALO, 1'b1, c_E_FETCH_R, "jal_fetch");
        step(0, c_JALO, 1'b1, c_E_DECODE,  "jal_decode");
        step(0, c_JALO, 1'b1, c_E_JAL,     "jal_pc");
        step(0, c_JALO, 1'b1, c_E_ALU_WB,  "jal_wb");
        step(0, c_JALRO, 1'b1, c_E_FETCH_R, "jalr_fetch");
        step(0, c_JALRO, 1'b1, c_E_DECODE,  "jalr_decode");
        step(0, c_JALRO, 1'b1, c_E_JALR,    "jalr_addr");
        step(0, c_JALRO, 1'b1, c_E_JAL,     "jalr_pc");
        step(0, c_JALRO, 1'b1, c_E_ALU_WB,  "jalr_wb");
        check_eq("jal_jalr_instret", instret(0), 32'd2);

        // branch, R-type, LUI, zero-wait store
        step(0, c_BEQ, 1'b1, c_E_FETCH_R, "br_fetch");
        step(0, c_BEQ, 1'b1, c_E_DECODE,  "br_decode");
        step(0, c_BEQ, 1'b1, c_E_BRANCH,  "br_cmp");
        check_eq("br_instret", instret(0), 32'd3);
        step(0, c_RT, 1'b1, c_E_FETCH_R, "r_fetch");
        step(0, c_RT, 1'b1, c_E_DECODE,  "r_decode");
        step(0, c_RT, 1'b1, c_E_EXEC_R,  "r_exec");
        step(0, c_RT, 1'b1, c_E_ALU_WB,  "r_wb");
        step(0, c_LUIO, 1'b1, c_E_FETCH_R, "lui_fetch");
        step(0, c_LUIO, 1'b1, c_E_DECODE,  "lui_decode");
        step(0, c_LUIO, 1'b1, c_E_LUI,     "lui_exec");
        step(0, c_LUIO, 1'b1, c_E_ALU_WB,  "lui_wb");
        step(0, c_SW, 1'b1, c_E_FETCH_R, "sw2_fetch");
        step(0, c_SW, 1'b1, c_E_DECODE,  "sw2_decode");
        step(0, c_SW, 1'b1, c_E_MEM_ADR, "sw2_adr");
        step(0, c_SW, 1'b1, c_E_MEM_WR,  "sw2_write");
        check_eq("mix_instret", instret(0), 32'd6);

        // illegal opcode
        step(0, c_BAD, 1'b1, c_E_FETCH_R, "ill_fetch");
        step(0, c_BAD, 1'b1, c_E_DECODE,  "ill_decode");
        check_eq("ill_trap", {31'd0, w_trap[0]}, 32'd1);
        check_eq("ill_cause", {30'd0, w_cause[0]}, 32'd1);
        step(0, c_ADDI, 1'b1, c_E_ZERO, "trap_idle0");
        step(0, c_LW,   1'b0, c_E_ZERO, "trap_idle1");
        check_eq("trap_hold", {29'd0, w_trap[0], w_cause[0]}, 32'd5);
        check_eq("trap_instret", instret(0), 32'd6);
        do_reset(0);

        // ---------------- instance 1: timeout and wrap ----------------
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1, c_ADDI, 1'b0, c_E_FETCH_W, "to_fetch_wait");
        check_eq("to_trap", {31'd0, w_trap[1]}, 32'd1);
        check_eq("to_cause", {30'd0, w_cause[1]}, 32'd2);
        step(1, c_ADDI, 1'b1, c_E_ZERO, "to_trap_idle");
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1, c_ADDI, 1'b0, c_E_FETCH_W, "edge_wait");
        step(1, c_ADDI, 1'b1, c_E_FETCH_R, "edge_ready");
        step(1, c_ADDI, 1'b1, c_E_DECODE,  "edge_decode");
        check_eq("edge_no_trap", {31'd0, w_trap[1]}, 32'd0);
        step(1, c_ADDI, 1'b1, c_E_EXEC_I, "edge_exec");
        step(1, c_ADDI, 1'b1, c_E_ALU_WB, "edge_wb");
        check_eq("wrap_1", instret(1), 32'd1);
        for (int k = 0; k < 7; k++) begin
            run_addi(1);
            check_eq("wrap_cnt", instret(1), 32'((k + 2) % 8));
        end
        // load that never completes times out in MEM_READ
        step(1, c_LW, 1'b1, c_E_FETCH_R, "lwto_fetch");
        step(1, c_LW, 1'b1, c_E_DECODE,  "lwto_decode");
        step(1, c_LW, 1'b1, c_E_MEM_ADR, "lwto_adr");
        for (int i = 0; i < 4; i++) step(1, c_LW, 1'b0, c_E_MEM_RD, "lwto_wait");
        check_eq("lwto_trap", {29'd0, w_trap[1], w_cause[1]}, 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
